clk_trig_sequencer: RTL and testbench

- Controller for the clock-and-trigger datapath. Generates the `trigger` that the trigger-modulated clock generators consume, as programmable bursts.
- Arbitrates changes of the clock-source select between the divided clock (src 0) and the duty-cycle clock (src 1).
- A source change is allowed only while idle, after a guard interval. This keeps the downstream 2-stage negedge synchronizers and the output clock settled.
- Sits between the operator or test-control inputs and the clock-generator pair.

---
 rtl/clk_trig_sequencer_pkg.sv | 21 ++
 rtl/clk_trig_sequencer_if.sv | 40 ++++
 rtl/clk_trig_sequencer_seq_down_counter.sv | 35 +++
 rtl/clk_trig_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_clk_trig_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/clk_trig_sequencer_pkg.sv
// clk_trig_sequencer_pkg
//   Shared definitions for the clock-and-trigger sequencer:
//   - state_t       : sequencer FSM state encoding
//   - CNT_W_DEF     : default width of the high/gap length counters
//   - BURST_W_DEF   : default width of the burst-count field
//   - GUARD_CYC_DEF : default source-switch guard length in fastclk cycles
package clk_trig_sequencer_pkg;

   localparam int CNT_W_DEF     = 8;
   localparam int BURST_W_DEF   = 4;
   localparam int GUARD_CYC_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HIGH   = 3'd1,
      ST_GAP    = 3'd2,
      ST_DONE   = 3'd3,
      ST_SWITCH = 3'd4
   } state_t;

endpackage

// File: rtl/clk_trig_sequencer_if.sv
// clk_trig_sequencer_if
//   Control/status bundle between the operator (or test control) side and
//   the sequencer.
//   Control side -> sequencer : start, abort, high_len, gap_len, burst_cnt,
//                               src_req
//   Sequencer -> control side : trigger, src_sel, busy, done, err, state_dbg
//   Handshake: start is a one-cycle request, sampled only while busy is low;
//   no ready is returned -- a start seen while busy is simply dropped, and
//   done / err are one-cycle completion / rejection pulses.
//   state_dbg exposes the FSM state for observation only.
//   Modports: master = control side, slave = sequencer.
interface clk_trig_sequencer_if
   import clk_trig_sequencer_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int BURST_W = BURST_W_DEF
);
   logic               start;
   logic               abort;
   logic [CNT_W-1:0]   high_len;
   logic [CNT_W-1:0]   gap_len;
   logic [BURST_W-1:0] burst_cnt;
   logic               src_req;
   logic               trigger;
   logic               src_sel;
   logic               busy;
   logic               done;
   logic               err;
   state_t             state_dbg;

   modport master (
      output start, abort, high_len, gap_len, burst_cnt, src_req,
      input  trigger, src_sel, busy, done, err, state_dbg
   );

   modport slave (
      input  start, abort, high_len, gap_len, burst_cnt, src_req,
      output trigger, src_sel, busy, done, err, state_dbg
   );
endinterface

// File: rtl/clk_trig_sequencer_seq_down_counter.sv
// seq_down_counter
//   Loadable down-counter used for phase lengths and the switch guard.
//   Ports:
//     fastclk  : clock
//     reset    : asynchronous, active-high; clears the count
//     load     : load load_val (has priority over en)
//     en       : decrement by one, holding at zero
//     load_val : value to load
//     expire   : count equals 1, i.e. the current cycle is the last one
//                of the loaded interval
module seq_down_counter #(
   parameter int CNT_W = 8
) (
   input  logic             fastclk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // Counting from N down to 1 gives exactly N cycles for the interval.
   assign expire = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/clk_trig_sequencer.sv
// clk_trig_sequencer
//   Generates programmable trigger bursts for the trigger-modulated clock
//   generators and arbitrates clock-source changes between the divided
//   clock (src 0) and the duty-cycle clock (src 1). A source change is
//   committed only from idle, after a guard interval long enough for the
//   downstream negedge synchronizers to settle.
//   Ports:
//     fastclk : system clock, posedge
//     reset   : asynchronous, active-high
//     bus     : clk_trig_sequencer_if.slave (start, abort, config, src_req
//               in; trigger, src_sel, busy, done, err, state_dbg out)
//   All outputs are registered.
module clk_trig_sequencer
   import clk_trig_sequencer_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int BURST_W   = BURST_W_DEF,
   parameter int GUARD_CYC = GUARD_CYC_DEF
) (
   input  logic                 fastclk,
   input  logic                 reset,
   clk_trig_sequencer_if.slave  bus
);
   state_t             state;
   logic [CNT_W-1:0]   high_len_q;
   logic [CNT_W-1:0]   gap_len_q;
   logic [BURST_W-1:0] burst_q;
   logic               trigger_q;
   logic               src_sel_q;
   logic               busy_q;
   logic               done_q;
   logic               err_q;

   logic               ph_load;
   logic               ph_en;
   logic [CNT_W-1:0]   ph_val;
   logic               ph_expire;
   logic               gd_load;
   logic               gd_en;
   logic               gd_expire;
   logic               abort_act;
   logic               cfg_ok;
   logic               src_change;

   assign abort_act  = bus.abort && (state != ST_IDLE);
   assign cfg_ok     = (bus.high_len != '0) && (bus.burst_cnt != '0);
   assign src_change = (bus.src_req != src_sel_q);

   // Counter control mirrors the FSM transitions below.
   always_comb begin
      ph_load = 1'b0;
      ph_en   = 1'b0;
      ph_val  = high_len_q;
      gd_load = 1'b0;
      gd_en   = 1'b0;
      if (!abort_act) begin
         case (state)
            ST_IDLE: begin
               if (src_change) begin
                  gd_load = 1'b1;
               end else if (bus.start && cfg_ok) begin
                  ph_load = 1'b1;
                  ph_val  = bus.high_len;
               end
            end
            ST_HIGH: begin
               if (ph_expire) begin
                  if (burst_q != BURST_W'(1)) begin
                     ph_load = 1'b1;
                     // A zero gap skips GAP and reloads the next HIGH phase.
                     ph_val  = (gap_len_q == '0) ? high_len_q : gap_len_q;
                  end
               end else begin
                  ph_en = 1'b1;
               end
            end
            ST_GAP: begin
               if (ph_expire) begin
                  ph_load = 1'b1;
                  ph_val  = high_len_q;
               end else begin
                  ph_en = 1'b1;
               end
            end
            ST_SWITCH: gd_en = 1'b1;
            default: ;
         endcase
      end
   end

   seq_down_counter #(.CNT_W(CNT_W)) u_phase_cnt (
      .fastclk  (fastclk),
      .reset    (reset),
      .load     (ph_load),
      .en       (ph_en),
      .load_val (ph_val),
      .expire   (ph_expire)
   );

   seq_down_counter #(.CNT_W(CNT_W)) u_guard_cnt (
      .fastclk  (fastclk),
      .reset    (reset),
      .load     (gd_load),
      .en       (gd_en),
      .load_val (CNT_W'(GUARD_CYC)),
      .expire   (gd_expire)
   );

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         high_len_q <= '0;
         gap_len_q  <= '0;
         burst_q    <= '0;
         trigger_q  <= 1'b0;
         src_sel_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (abort_act) begin
            // No partial commit: src_sel and done are left untouched.
            state     <= ST_IDLE;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  trigger_q <= 1'b0;
                  // A pending source change wins; a coincident start is dropped.
                  if (src_change) begin
                     state  <= ST_SWITCH;
                     busy_q <= 1'b1;
                  end else if (bus.start) begin
                     if (!cfg_ok) begin
                        err_q <= 1'b1;
                     end else begin
                        high_len_q <= bus.high_len;
                        gap_len_q  <= bus.gap_len;
                        burst_q    <= bus.burst_cnt;
                        state      <= ST_HIGH;
                        trigger_q  <= 1'b1;
                        busy_q     <= 1'b1;
                     end
                  end
               end
               ST_HIGH: begin
                  if (ph_expire) begin
                     burst_q <= burst_q - 1'b1;
                     if (burst_q == BURST_W'(1)) begin
                        state     <= ST_DONE;
                        trigger_q <= 1'b0;
                        done_q    <= 1'b1;
                     end else if (gap_len_q == '0) begin
                        state     <= ST_HIGH;
                        trigger_q <= 1'b1;
                     end else begin
                        state     <= ST_GAP;
                        trigger_q <= 1'b0;
                     end
                  end
               end
               ST_GAP: begin
                  if (ph_expire) begin
                     state     <= ST_HIGH;
                     trigger_q <= 1'b1;
                  end
               end
               ST_DONE: begin
                  state     <= ST_IDLE;
                  trigger_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
               ST_SWITCH: begin
                  trigger_q <= 1'b0;
                  if (gd_expire) begin
                     // Commit whatever is requested at expiry, even if it reverted.
                     src_sel_q <= bus.src_req;
                     state     <= ST_IDLE;
                     busy_q    <= 1'b0;
                  end
               end
               default: begin
                  state     <= ST_IDLE;
                  trigger_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.trigger   = trigger_q;
   assign bus.src_sel   = src_sel_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.state_dbg = state;
endmodule

// File: tb/tb_clk_trig_sequencer.sv
// tb_clk_trig_sequencer
//   Table-driven check of burst patterns and configuration rejection,
//   followed by hand-written sequences for reset, source switching, abort,
//   start-while-busy and the maximum high length.
module tb_clk_trig_sequencer;
   import clk_trig_sequencer_pkg::*;

   logic fastclk;
   logic reset;

   clk_trig_sequencer_if #(.CNT_W(8), .BURST_W(4)) bus ();

   clk_trig_sequencer #(.CNT_W(8), .BURST_W(4), .GUARD_CYC(4)) dut (
      .fastclk (fastclk),
      .reset   (reset),
      .bus     (bus)
   );

   // ---------------- clock / reset ----------------
   initial fastclk = 1'b0;
   always #5 fastclk = ~fastclk;

   int n_cmp;
   int n_fail;

   typedef struct {
      int          hl;
      int          gl;
      int          bc;
      logic        exp_err;
      int          len;     // trigger window length in cycles
      logic [31:0] pat;     // bit (len-k) is trigger in cycle k
   } vec_t;

   vec_t vecs[8];

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge fastclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_cfg(input int hl, input int gl, input int bc);
      bus.high_len  = 8'(hl);
      bus.gap_len   = 8'(gl);
      bus.burst_cnt = 4'(bc);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // ---------------- stimulus and scoreboard ----------------
   initial begin
      int cnt;
      n_cmp  = 0;
      n_fail = 0;

      vecs[0] = '{hl:3, gl:2, bc:2, exp_err:1'b0, len:8, pat:32'b11100111};
      vecs[1] = '{hl:2, gl:0, bc:3, exp_err:1'b0, len:6, pat:32'b111111};
      vecs[2] = '{hl:1, gl:1, bc:3, exp_err:1'b0, len:5, pat:32'b10101};
      vecs[3] = '{hl:4, gl:3, bc:1, exp_err:1'b0, len:4, pat:32'b1111};
      vecs[4] = '{hl:0, gl:2, bc:2, exp_err:1'b1, len:0, pat:32'b0};
      vecs[5] = '{hl:3, gl:1, bc:0, exp_err:1'b1, len:0, pat:32'b0};
      vecs[6] = '{hl:1, gl:0, bc:1, exp_err:1'b0, len:1, pat:32'b1};
      vecs[7] = '{hl:2, gl:5, bc:2, exp_err:1'b0, len:9, pat:32'b110000011};

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.src_req = 1'b0;
      set_cfg(0, 0, 0);
      repeat (3) @(posedge fastclk);
      #3 reset = 1'b0;
      tick();

      check("rst_trigger", 32'(bus.trigger), 0);
      check("rst_src_sel", 32'(bus.src_sel), 0);
      check("rst_busy",    32'(bus.busy), 0);
      check("rst_done",    32'(bus.done), 0);
      check("rst_err",     32'(bus.err), 0);
      check("rst_state",   32'(bus.state_dbg), 32'(ST_IDLE));

      // ---- table-driven vectors ----
      for (int i = 0; i < 8; i++) begin
         set_cfg(vecs[i].hl, vecs[i].gl, vecs[i].bc);
         pulse_start();
         if (vecs[i].exp_err) begin
            check($sformatf("v%0d_err", i), 32'(bus.err), 1);
            check($sformatf("v%0d_trig", i), 32'(bus.trigger), 0);
            check($sformatf("v%0d_busy", i), 32'(bus.busy), 0);
            tick();
            check($sformatf("v%0d_err_end", i), 32'(bus.err), 0);
            check($sformatf("v%0d_busy_end", i), 32'(bus.busy), 0);
         end else begin
            for (int k = 1; k <= vecs[i].len; k++) begin
               check($sformatf("v%0d_trig_c%0d", i, k), 32'(bus.trigger), 32'(vecs[i].pat[vecs[i].len - k]));
               check($sformatf("v%0d_busy_c%0d", i, k), 32'(bus.busy), 1);
               check($sformatf("v%0d_done_c%0d", i, k), 32'(bus.done), 0);
               tick();
            end
            check($sformatf("v%0d_done", i), 32'(bus.done), 1);
            check($sformatf("v%0d_trig_done", i), 32'(bus.trigger), 0);
            check($sformatf("v%0d_busy_done", i), 32'(bus.busy), 1);
            tick();
            check($sformatf("v%0d_done_end", i), 32'(bus.done), 0);
            check($sformatf("v%0d_busy_end", i), 32'(bus.busy), 0);
         end
         check($sformatf("v%0d_err_none", i), 32'(bus.err), 0);
         tick();
      end

      // ---- reset mid-HIGH ----
      set_cfg(8, 0, 1);
      pulse_start();
      tick();
      tick();
      check("rstmid_trig_before", 32'(bus.trigger), 1);
      reset = 1'b1;
      #1;
      check("rstmid_trig_async", 32'(bus.trigger), 0);
      check("rstmid_busy_async", 32'(bus.busy), 0);
      #2 reset = 1'b0;
      tick();
      check("rstmid_state", 32'(bus.state_dbg), 32'(ST_IDLE));
      check("rstmid_busy", 32'(bus.busy), 0);
      pulse_start();
      cnt = 0;
      for (int k = 0; k < 20 && bus.trigger; k++) begin
         cnt++;
         tick();
      end
      check("rstmid_high_cycles", 32'(cnt), 8);
      check("rstmid_done", 32'(bus.done), 1);
      tick();
      tick();

      // ---- source switch with coincident start ----
      set_cfg(3, 0, 1);
      bus.src_req = 1'b1;
      pulse_start();
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("sw_busy_c%0d", k), 32'(bus.busy), 1);
         check($sformatf("sw_trig_c%0d", k), 32'(bus.trigger), 0);
         check($sformatf("sw_sel_c%0d", k), 32'(bus.src_sel), 0);
         check($sformatf("sw_done_c%0d", k), 32'(bus.done | bus.err), 0);
         tick();
      end
      check("sw_busy_end", 32'(bus.busy), 0);
      check("sw_sel_end", 32'(bus.src_sel), 1);
      check("sw_trig_end", 32'(bus.trigger), 0);
      check("sw_done_err_end", 32'(bus.done | bus.err), 0);
      tick();
      check("sw_start_dropped", 32'(bus.busy), 0);

      // ---- switch request that reverts during the guard ----
      bus.src_req = 1'b0;
      tick();
      bus.src_req = 1'b1;
      check("rev_busy_c1", 32'(bus.busy), 1);
      repeat (3) tick();
      check("rev_busy_c4", 32'(bus.busy), 1);
      tick();
      check("rev_busy_end", 32'(bus.busy), 0);
      check("rev_sel_end", 32'(bus.src_sel), 1);
      tick();

      // ---- abort in the 2nd burst ----
      set_cfg(5, 2, 3);
      pulse_start();
      repeat (8) tick();
      check("ab_trig_c9", 32'(bus.trigger), 1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("ab_trig", 32'(bus.trigger), 0);
      check("ab_busy", 32'(bus.busy), 0);
      check("ab_state", 32'(bus.state_dbg), 32'(ST_IDLE));
      check("ab_done", 32'(bus.done), 0);
      check("ab_sel", 32'(bus.src_sel), 1);
      set_cfg(2, 0, 1);
      pulse_start();
      check("ab_restart_trig", 32'(bus.trigger), 1);
      check("ab_restart_done", 32'(bus.done), 0);
      tick();
      check("ab_restart_trig2", 32'(bus.trigger), 1);
      tick();
      check("ab_restart_fin", 32'(bus.done), 1);
      tick();

      // ---- abort in IDLE has no effect ----
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abidle_busy", 32'(bus.busy), 0);
      check("abidle_sel", 32'(bus.src_sel), 1);

      // ---- start while busy ignored, config changes ignored ----
      set_cfg(4, 0, 1);
      pulse_start();
      set_cfg(0, 7, 0);
      pulse_start();
      check("sb_err", 32'(bus.err), 0);
      check("sb_trig_c2", 32'(bus.trigger), 1);
      tick();
      tick();
      check("sb_trig_c4", 32'(bus.trigger), 1);
      tick();
      check("sb_done", 32'(bus.done), 1);
      tick();
      tick();

      // ---- maximum high length, no wrap ----
      set_cfg(255, 0, 1);
      pulse_start();
      cnt = 0;
      for (int k = 0; k < 300 && bus.trigger; k++) begin
         cnt++;
         tick();
      end
      check("max_high_cycles", 32'(cnt), 255);
      check("max_done", 32'(bus.done), 1);
      tick();
      check("max_busy_end", 32'(bus.busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
